alu_test_sequencer: RTL

//  Sequences the ALU tester. On start it walks a vector ROM one entry at a time, drives the ALU operands/opcode,
//  and presents the expected 15-bit result ({agrtb,aeqb,altb,result[11:0]}) to the comparator.
//  It then samples the comparator's 8-bit ErrOut (8'h00 pass / 8'hFF fail) and accumulates a failure count.
//  It reports done/pass plus the first failing vector address.

---
 rtl/alu_test_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/alu_test_sequencer.sv
// ALU tester sequencer: walks a synchronous vector ROM, drives the ALU operands and the expected result,
// samples the comparator error byte for each vector and reports pass, the failure count and the first failing address.
module alu_test_sequencer #(
   parameter int NUM_VECTORS = 16,
   parameter int ADDR_W      = 4,
   parameter int ALU_LAT     = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   output logic [ADDR_W-1:0] vec_addr,
   input  logic [42:0]       vec_data,
   output logic [3:0]        alu_op,
   output logic [11:0]       alu_a,
   output logic [11:0]       alu_b,
   output logic [14:0]       res_exp,
   input  logic [7:0]        err_in,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W:0]   err_count,
   output logic [ADDR_W-1:0] first_fail_addr,
   output logic              first_fail_vld
);

   localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
   localparam logic [CNT_W-1:0]  WAIT_LOAD = CNT_W'(ALU_LAT - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_VECTORS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_APPLY,
      S_WAIT,
      S_CHECK,
      S_DONE
   } state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_wait_cnt;
   logic [ADDR_W-1:0] r_vec_addr;
   logic [3:0]        r_alu_op;
   logic [11:0]       r_alu_a;
   logic [11:0]       r_alu_b;
   logic [14:0]       r_res_exp;
   logic              r_busy;
   logic              r_done;
   logic              r_pass;
   logic [ADDR_W:0]   r_err_count;
   logic [ADDR_W-1:0] r_first_fail_addr;
   logic              r_first_fail_vld;

   logic              w_fail;
   logic              w_last;
   logic [ADDR_W:0]   w_err_next;

   assign w_fail     = (err_in != '0);
   assign w_last     = (r_vec_addr == LAST_ADDR);
   // Count saturates at all-ones instead of wrapping.
   assign w_err_next = (!w_fail || (&r_err_count)) ? r_err_count
                                                   : r_err_count + (ADDR_W+1)'(1);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state           <= S_IDLE;
         r_wait_cnt        <= '0;
         r_vec_addr        <= '0;
         r_alu_op          <= '0;
         r_alu_a           <= '0;
         r_alu_b           <= '0;
         r_res_exp         <= '0;
         r_busy            <= 1'b0;
         r_done            <= 1'b0;
         r_pass            <= 1'b0;
         r_err_count       <= '0;
         r_first_fail_addr <= '0;
         r_first_fail_vld  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               // A simultaneous abort suppresses the start.
               if (start && !abort) begin
                  r_state           <= S_FETCH;
                  r_vec_addr        <= '0;
                  r_err_count       <= '0;
                  r_first_fail_addr <= '0;
                  r_first_fail_vld  <= 1'b0;
                  r_done            <= 1'b0;
                  r_pass            <= 1'b0;
                  r_busy            <= 1'b1;
               end
            end
            default: begin
               if (abort) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_pass  <= 1'b0;
               end else begin
                  case (r_state)
                     S_FETCH: r_state <= S_APPLY;
                     S_APPLY: begin
                        r_alu_op   <= vec_data[42:39];
                        r_alu_a    <= vec_data[38:27];
                        r_alu_b    <= vec_data[26:15];
                        r_res_exp  <= vec_data[14:0];
                        r_wait_cnt <= WAIT_LOAD;
                        r_state    <= S_WAIT;
                     end
                     S_WAIT: begin
                        if (r_wait_cnt == '0) begin
                           r_state <= S_CHECK;
                        end else begin
                           r_wait_cnt <= r_wait_cnt - CNT_W'(1);
                        end
                     end
                     S_CHECK: begin
                        r_err_count <= w_err_next;
                        if (w_fail && !r_first_fail_vld) begin
                           r_first_fail_addr <= r_vec_addr;
                           r_first_fail_vld  <= 1'b1;
                        end
                        if (w_last) begin
                           r_state <= S_DONE;
                           r_busy  <= 1'b0;
                           r_done  <= 1'b1;
                           r_pass  <= (w_err_next == '0);
                        end else begin
                           r_vec_addr <= r_vec_addr + ADDR_W'(1);
                           r_state    <= S_FETCH;
                        end
                     end
                     default: r_state <= S_IDLE;
                  endcase
               end
            end
         endcase
      end
   end

   assign vec_addr        = r_vec_addr;
   assign alu_op          = r_alu_op;
   assign alu_a           = r_alu_a;
   assign alu_b           = r_alu_b;
   assign res_exp         = r_res_exp;
   assign busy            = r_busy;
   assign done            = r_done;
   assign pass            = r_pass;
   assign err_count       = r_err_count;
   assign first_fail_addr = r_first_fail_addr;
   assign first_fail_vld  = r_first_fail_vld;

endmodule
